// File: rtl/mtm_alu_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mtm_alu_pkg: shared opcode, frame and error definitions plus CRC helpers.
// Rev 1.0
// ----------------------------------------------------------------------------
package mtm_alu_pkg;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b100,
        OP_SUB = 3'b101
    } operation_t;

    localparam logic FRAME_DATA = 1'b0;
    localparam logic FRAME_CTL  = 1'b1;

    localparam int ERR_DATA_BIT = 2;
    localparam int ERR_CRC_BIT  = 1;
    localparam int ERR_OP_BIT   = 0;

    // x^4 + x + 1, init 0, MSB first over {A, B, 1'b1, op}
    function automatic logic [3:0] crc4(input logic [67:0] d);
        logic [3:0] c;
        logic       fb;
        c = 4'h0;
        for (int i = 67; i >= 0; i--) begin
            fb = c[3] ^ d[i];
            c  = {c[2], c[1], c[0] ^ fb, fb};
        end
        return c;
    endfunction

    // x^3 + x + 1, init 0, MSB first
    function automatic logic [2:0] crc3(input logic [36:0] d);
        logic [2:0] c;
        logic       fb;
        c = 3'h0;
        for (int i = 36; i >= 0; i--) begin
            fb = c[2] ^ d[i];
            c  = {c[1], c[0] ^ fb, fb};
        end
        return c;
    endfunction

    function automatic logic is_valid_op(input logic [2:0] op);
        return op inside {OP_AND, OP_OR, OP_ADD, OP_SUB};
    endfunction

endpackage
`default_nettype wire

// File: rtl/mtm_alu_crc4_serial.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mtm_alu_crc4_serial: bit-serial CRC4 (x^4+x+1) LFSR, one bit per enabled clock.
// Rev 1.0
// ----------------------------------------------------------------------------
module mtm_alu_crc4_serial (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr,
    input  logic       en,
    input  logic       din,
    output logic [3:0] crc_o
);

    logic [3:0] crc_q;
    logic       w_fb;

    assign w_fb  = crc_q[3] ^ din;
    assign crc_o = crc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc_q <= 4'h0;
        end else if (clr) begin
            crc_q <= 4'h0;
        end else if (en) begin
            crc_q <= {crc_q[2], crc_q[1], crc_q[0] ^ w_fb, w_fb};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mtm_alu_deserializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mtm_alu_deserializer: samples sin, assembles frames into {A, B, op} and checks them.
// Rev 1.0
// ----------------------------------------------------------------------------
module mtm_alu_deserializer
    import mtm_alu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sin,
    output logic        out_valid,
    output logic [31:0] out_A,
    output logic [31:0] out_B,
    output logic [2:0]  out_op,
    output logic        out_err,
    output logic [2:0]  out_err_flags
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TYPE = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_STOP = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [2:0]  bit_cnt_q;
    logic        frame_type_q;
    logic [7:0]  payload_q;
    logic [3:0]  byte_cnt_q;
    logic [63:0] ab_q;
    logic        frame_bad_q;

    logic        out_valid_q;
    logic [31:0] out_a_q, out_b_q;
    logic [2:0]  out_op_q;
    logic [2:0]  out_flags_q;

    logic        w_shift;
    logic        w_data_end;
    logic        w_ctl_end;
    logic        w_crc_en;
    logic        w_crc_din;
    logic [3:0]  w_crc;
    logic [2:0]  w_flags;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (!sin) state_d = S_TYPE;
            S_TYPE:  state_d = S_DATA;
            S_DATA:  if (bit_cnt_q == 3'd7) state_d = S_STOP;
            S_STOP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        w_shift    = (state_q == S_DATA);
        w_data_end = (state_q == S_STOP) && (frame_type_q == FRAME_DATA);
        w_ctl_end  = (state_q == S_STOP) && (frame_type_q == FRAME_CTL);
        // Control payload MSB is a fixed 0 on the line but enters the CRC as 1
        w_crc_en   = w_shift && ((frame_type_q == FRAME_DATA) ? (byte_cnt_q < 4'd8)
                                                               : !bit_cnt_q[2]);
        w_crc_din  = ((frame_type_q == FRAME_CTL) && (bit_cnt_q == 3'd0)) ? 1'b1 : sin;

        w_flags = 3'b000;
        if ((byte_cnt_q != 4'd8) || frame_bad_q || !sin) begin
            w_flags[ERR_DATA_BIT] = 1'b1;
        end else if (w_crc != payload_q[3:0]) begin
            w_flags[ERR_CRC_BIT] = 1'b1;
        end else if (!is_valid_op(payload_q[6:4])) begin
            w_flags[ERR_OP_BIT] = 1'b1;
        end
    end

    mtm_alu_crc4_serial u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_ctl_end),
        .en    (w_crc_en),
        .din   (w_crc_din),
        .crc_o (w_crc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q    <= 3'd0;
            frame_type_q <= FRAME_DATA;
            payload_q    <= 8'h00;
            byte_cnt_q   <= 4'd0;
            ab_q         <= 64'h0;
            frame_bad_q  <= 1'b0;
            out_valid_q  <= 1'b0;
            out_a_q      <= 32'h0;
            out_b_q      <= 32'h0;
            out_op_q     <= 3'b000;
            out_flags_q  <= 3'b000;
        end else begin
            out_valid_q <= 1'b0;
            if (state_q == S_TYPE) begin
                frame_type_q <= sin;
                bit_cnt_q    <= 3'd0;
            end
            if (w_shift) begin
                payload_q <= {payload_q[6:0], sin};
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end
            if (w_data_end) begin
                if (!sin) begin
                    frame_bad_q <= 1'b1;
                end else begin
                    if (byte_cnt_q < 4'd8) ab_q <= {ab_q[55:0], payload_q};
                    if (byte_cnt_q < 4'd9) byte_cnt_q <= byte_cnt_q + 4'd1;
                end
            end
            if (w_ctl_end) begin
                out_valid_q <= 1'b1;
                out_a_q     <= ab_q[63:32];
                out_b_q     <= ab_q[31:0];
                out_op_q    <= payload_q[6:4];
                out_flags_q <= w_flags;
                byte_cnt_q  <= 4'd0;
                ab_q        <= 64'h0;
                frame_bad_q <= 1'b0;
            end
        end
    end

    assign out_valid     = out_valid_q;
    assign out_A         = out_a_q;
    assign out_B         = out_b_q;
    assign out_op        = out_op_q;
    assign out_err_flags = out_flags_q;
    assign out_err       = |out_flags_q;

endmodule
`default_nettype wire

// File: tb/tb_mtm_alu_deserializer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mtm_alu_deserializer: directed and random packets against a behavioural model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mtm_alu_deserializer;
    import mtm_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        sin;
    logic        out_valid;
    logic [31:0] out_A, out_B;
    logic [2:0]  out_op;
    logic        out_err;
    logic [2:0]  out_err_flags;

    mtm_alu_deserializer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sin           (sin),
        .out_valid     (out_valid),
        .out_A         (out_A),
        .out_B         (out_B),
        .out_op        (out_op),
        .out_err       (out_err),
        .out_err_flags (out_err_flags)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          due;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [2:0]  flags;
    } exp_t;

    exp_t expq[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic [70:0] last_out = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Remainder of M(x)*x^4 divided by x^4+x+1, by long division
    function automatic logic [3:0] model_crc(input logic [67:0] m);
        logic [71:0] r;
        r = {m, 4'b0000};
        for (int i = 71; i >= 4; i--)
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        return r[3:0];
    endfunction

    task automatic send_bit(input logic b);
        @(negedge clk);
        sin = b;
    endtask

    task automatic send_frame(input logic typ, input logic [7:0] pay, input logic stop);
        send_bit(1'b0);
        send_bit(typ);
        for (int i = 7; i >= 0; i--) send_bit(pay[i]);
        send_bit(stop);
    endtask

    task automatic send_packet(input logic [63:0] ab, input int ndata, input logic [2:0] op,
                               input logic [3:0] crc_x, input int bad_idx);
        logic [63:0] ab_rx;
        logic [7:0]  byt;
        logic [3:0]  crc_tx;
        int          cnt;
        bit          bad;
        exp_t        e;
        ab_rx = '0;
        cnt   = 0;
        bad   = 0;
        for (int i = 0; i < ndata; i++) begin
            byt = (i < 8) ? ab[63 - 8*i -: 8] : 8'($urandom);
            send_frame(FRAME_DATA, byt, (i != bad_idx));
            if (i == bad_idx) bad = 1;
            else begin
                if (cnt < 8) ab_rx = {ab_rx[55:0], byt};
                cnt++;
            end
        end
        crc_tx = model_crc({ab, 1'b1, op}) ^ crc_x;
        send_frame(FRAME_CTL, {1'b0, op, crc_tx}, 1'b1);
        e.due = cyc + 1;
        e.a   = ab_rx[63:32];
        e.b   = ab_rx[31:0];
        e.op  = op;
        if (cnt != 8 || bad)                                   e.flags = 3'b100;
        else if (crc_tx != model_crc({ab_rx, 1'b1, op}))       e.flags = 3'b010;
        else if (!(op inside {3'b000, 3'b001, 3'b100, 3'b101})) e.flags = 3'b001;
        else                                                   e.flags = 3'b000;
        expq.push_back(e);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && expq.size() != 0; i++) @(negedge clk);
        check("drain_pending", 64'(expq.size()), 64'd0);
    endtask

    task automatic expect_out(input logic [31:0] a, input logic [31:0] b,
                              input logic [2:0] op, input logic [2:0] flags);
        check("dir_A", 64'(out_A), 64'(a));
        check("dir_B", 64'(out_B), 64'(b));
        check("dir_op", 64'(out_op), 64'(op));
        check("dir_flags", 64'(out_err_flags), 64'(flags));
        check("dir_err", 64'(out_err), 64'(flags != 3'b000));
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            check("reset_outputs", 64'({out_valid, out_A, out_B, out_op, out_err, out_err_flags}), 64'd0);
            check("reset_outputs_hi", 64'(out_A), 64'd0);
            last_out = '0;
        end else if (out_valid) begin
            if (expq.size() == 0) begin
                check("unexpected_valid", 64'(out_valid), 64'd0);
            end else begin
                e = expq.pop_front();
                check("valid_latency", 64'(cyc), 64'(e.due));
                check("out_A", 64'(out_A), 64'(e.a));
                check("out_B", 64'(out_B), 64'(e.b));
                check("out_op", 64'(out_op), 64'(e.op));
                check("out_err_flags", 64'(out_err_flags), 64'(e.flags));
                check("out_err", 64'(out_err), 64'(e.flags != 3'b000));
            end
            last_out = {out_A, out_B, out_op, out_err, out_err_flags};
        end else begin
            check("hold_A", 64'(out_A), 64'(last_out[70:39]));
            check("hold_rest", {out_B, out_op, out_err, out_err_flags}, 64'(last_out[38:0]));
            if (expq.size() != 0 && expq[0].due < cyc) begin
                check("missing_valid", 64'(out_valid), 64'd1);
                void'(expq.pop_front());
            end
        end
    end

    initial begin
        logic [67:0] w;
        logic [63:0] ab;
        logic [3:0]  cx;
        int          nd;
        int          bi;
        rst_n = 1'b0;
        sin   = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_flags", 64'(out_err_flags), 64'd0);
        @(posedge clk); #2 rst_n = 1'b1;

        check("model_crc_zero", 64'(model_crc(68'h0)), 64'h0);
        check("model_crc_one", 64'(model_crc(68'h1)), 64'h3);
        check("model_crc_two", 64'(model_crc(68'h2)), 64'h6);
        for (int i = 0; i < 16; i++) begin
            w = {4'($urandom), $urandom, $urandom};
            check("pkg_crc4", 64'(crc4(w)), 64'(model_crc(w)));
        end

        send_packet({32'h1, 32'h2}, 8, 3'b100, 4'h0, -1);
        drain();
        expect_out(32'h1, 32'h2, 3'b100, 3'b000);

        send_packet({32'h1, 32'h2}, 8, 3'b100, 4'h1, -1);
        drain();
        expect_out(32'h1, 32'h2, 3'b100, 3'b010);

        send_packet({32'hFFFF_FFFF, 32'h0}, 8, 3'b011, 4'h0, -1);
        drain();
        expect_out(32'hFFFF_FFFF, 32'h0, 3'b011, 3'b001);

        send_packet({32'h1111_2222, 32'h3344_5566}, 7, 3'b000, 4'h0, -1);
        drain();
        check("dir_7frames_flags", 64'(out_err_flags), 64'b100);
        check("dir_7frames_err", 64'(out_err), 64'd1);
        send_packet({32'h5, 32'h3}, 8, 3'b101, 4'h0, -1);
        drain();
        expect_out(32'h5, 32'h3, 3'b101, 3'b000);

        send_packet(64'h0, 0, 3'b000, 4'h0, -1);
        drain();
        check("dir_zero_data_flags", 64'(out_err_flags), 64'b100);

        send_packet({32'hA5A5_0F0F, 32'h1234_5678}, 8, 3'b001, 4'h0, 3);
        drain();
        check("dir_bad_stop_flags", 64'(out_err_flags), 64'b100);

        for (int i = 0; i < 5; i++) send_frame(FRAME_DATA, 8'($urandom), 1'b1);
        @(posedge clk); #2 rst_n = 1'b0;
        @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;
        send_packet({32'h1234_5678, 32'h9ABC_DEF0}, 8, 3'b000, 4'h0, -1);
        drain();
        expect_out(32'h1234_5678, 32'h9ABC_DEF0, 3'b000, 3'b000);

        for (int p = 0; p < 500; p++) begin
            ab = {$urandom, $urandom};
            nd = ($urandom_range(0, 99) < 85) ? 8 : int'($urandom_range(0, 10));
            bi = (nd > 0 && $urandom_range(0, 19) == 0) ? int'($urandom_range(0, nd - 1)) : -1;
            cx = ($urandom_range(0, 6) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            send_packet(ab, nd, 3'($urandom_range(0, 7)), cx, bi);
        end
        drain();
        repeat (5) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
